lcd_cfah_emul: RTL and testbench
================================

LCD_CFAH_EMUL -- requirements
Module: lcd_cfah_emul

Interface
REQ-001 SHALL have parameter G_RECEIVED_CMD_BUFFER_SIZE, default 256: depth of the internal received-command buffer.
REQ-002 SHALL use one clock and a synchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port i_rs, input, 1 bit: register select; 0 = command, 1 = data.
REQ-006 SHALL have port i_rw, input, 1 bit: 0 = write to the LCD, 1 = read from the LCD.
REQ-007 SHALL have port i_en, input, 1 bit: LCD enable strobe.
REQ-008 SHALL have port io_data, inout, 8 bits: LCD data bus.
REQ-009 SHALL have port i_busy_flag_duration, input, 8 bits: busy time in clk cycles after each write.
REQ-010 SHALL have port i_wdata, input, 8 bits: read-back value used when i_wdata_sel=1.
REQ-011 SHALL have port i_wdata_sel, input, 1 bit: read source; 0 = status, 1 = i_wdata.
REQ-012 SHALL have port o_rdata, output, 8 bits: last byte written by the host.
REQ-013 SHALL have port o_rdata_val, output, 1 bit: one-cycle strobe marking a new o_rdata.

Function
REQ-014 SHALL register i_en each cycle into en_q; a falling edge is en_q=1 and i_en=0.
REQ-015 SHALL, while i_en=1 and i_rw=0, latch io_data, i_rs and i_rw every cycle; the value latched on the last cycle with i_en=1 is the written byte.
REQ-016 SHALL, on a falling edge with latched rw=0, load o_rdata with the latched byte and set o_rdata_val=1 on that same clock edge.
REQ-017 SHALL return o_rdata_val to 0 on the next edge; o_rdata holds until the next write.
REQ-018 SHALL never pulse o_rdata_val for a read cycle (latched rw=1).
REQ-019 SHALL, on each accepted write, store {rs, byte} (9 bits) at the buffer write pointer and increment the pointer modulo G_RECEIVED_CMD_BUFFER_SIZE.
REQ-020 SHALL, when the buffer is full, overwrite the oldest entry on wrap-around; there is no full stall.
REQ-021 SHALL keep a saturating entry counter capped at G_RECEIVED_CMD_BUFFER_SIZE, readable hierarchically.
REQ-022 SHALL, on each accepted write, load the busy counter with i_busy_flag_duration, including writes made while already busy.
REQ-023 SHALL decrement the busy counter by 1 per cycle while it is nonzero.
REQ-024 SHALL define busy = (busy counter != 0); a duration of 0 means the device is never busy.
REQ-025 SHALL keep a 7-bit address counter (AC).
REQ-026 SHALL increment AC modulo 128 on each accepted write with rs=1.
REQ-027 SHALL clear AC to 0 on an accepted write with rs=0 and byte 0x01 (clear display) or 0x02 (return home).
REQ-028 SHALL load AC with byte[6:0] on an accepted write with rs=0 and byte[7]=1 (set DDRAM address).
REQ-029 SHALL drive io_data combinationally while i_en=1 and i_rw=1: {busy, AC} if i_wdata_sel=0, or i_wdata if i_wdata_sel=1.
REQ-030 SHALL keep io_data high-impedance at all other times, including during reset.
REQ-031 SHALL ignore i_rs during reads; status is returned for both rs values.
REQ-032 SHALL treat a write strobe that coincides with a busy countdown as accepted; no error is flagged.

Reset
REQ-033 SHALL, on a clock edge with rst_n=0, clear o_rdata to 0x00, o_rdata_val to 0, en_q to 0, the busy counter, AC, the buffer write pointer and the entry counter.
REQ-034 SHALL leave buffer contents undefined after reset.
REQ-035 SHALL abort any in-progress strobe when reset is asserted mid-operation, with no o_rdata_val generated for it.

Verification
REQ-036 SHALL pass this check: hold rst_n=0 for 5 cycles -> o_rdata=0x00, o_rdata_val=0, io_data=Z.
REQ-037 SHALL pass this check: rs=0, rw=0, data 0x38, i_en high for 10 cycles then low -> o_rdata=0x38 with o_rdata_val high for exactly 1 cycle; buffer[0]=0x038.
REQ-038 SHALL pass this check: i_busy_flag_duration=10, write 0x01, then read with i_wdata_sel=0 -> io_data[7]=1 within 10 cycles, io_data[7]=0 afterwards, io_data[6:0]=0.
REQ-039 SHALL pass this check: i_wdata_sel=1, i_wdata=0xA5, read strobe -> io_data=0xA5, o_rdata_val stays 0, io_data=Z after i_en falls.
REQ-040 SHALL pass this check: 257 writes with G_RECEIVED_CMD_BUFFER_SIZE=256 -> buffer[0] holds the 257th byte, entry counter=256.
REQ-041 SHALL pass this check: write with duration 200, assert rst_n=0 after 20 cycles, then read status -> io_data[7]=0 and AC=0.

Source files
------------

// File: rtl/lcd_cfah_emul.sv
// -----------------------------------------------------------------------------
// lcd_cfah_emul
// Behavioural emulation of an HD44780-style character LCD (CFAH family) as
// seen from the host bus. Host writes are captured on the falling edge of the
// enable strobe, logged into a circular command buffer, and used to update a
// busy countdown and the DDRAM address counter. Host reads return either the
// status byte {busy, AC} or a caller-supplied byte.
//
// Ports
//   clk                  system clock, all logic on rising edge
//   rst_n                synchronous active-low reset
//   i_rs                 register select (0 = command, 1 = data)
//   i_rw                 0 = host writes to LCD, 1 = host reads from LCD
//   i_en                 LCD enable strobe
//   io_data[7:0]         bidirectional LCD data bus
//   i_busy_flag_duration busy time in clk cycles after each write
//   i_wdata[7:0]         read-back byte used when i_wdata_sel = 1
//   i_wdata_sel          read source (0 = status, 1 = i_wdata)
//   o_rdata[7:0]         last byte written by the host
//   o_rdata_val          one-cycle strobe marking a new o_rdata
// -----------------------------------------------------------------------------
module lcd_cfah_emul #(
    parameter int G_RECEIVED_CMD_BUFFER_SIZE = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic       i_en,
    inout  wire  [7:0] io_data,
    input  logic [7:0] i_busy_flag_duration,
    input  logic [7:0] i_wdata,
    input  logic       i_wdata_sel,
    output logic [7:0] o_rdata,
    output logic       o_rdata_val
);

    localparam int PTR_W = (G_RECEIVED_CMD_BUFFER_SIZE > 1) ? $clog2(G_RECEIVED_CMD_BUFFER_SIZE) : 1;
    localparam int CNT_W = $clog2(G_RECEIVED_CMD_BUFFER_SIZE + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(G_RECEIVED_CMD_BUFFER_SIZE - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(G_RECEIVED_CMD_BUFFER_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Next address-counter value for an accepted write.
    function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic rs, input logic [7:0] b);
        logic [6:0] r;
        r = ac;
        if (rs) begin
            r = ac + 7'd1;
        end else if ((b == 8'h01) || (b == 8'h02)) begin
            r = 7'd0;
        end else if (b[7]) begin
            r = b[6:0];
        end else begin
            r = ac;
        end
        return r;
    endfunction

    logic             en_q;
    logic             abort_r;      // strobe already high at reset release: ignore it
    logic [7:0]       data_q_r;
    logic             rs_q_r;
    logic             rw_q_r;
    logic [7:0]       busy_cnt_r;
    logic [6:0]       ac_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] entry_cnt_r;
    logic [8:0]       cmd_buffer [G_RECEIVED_CMD_BUFFER_SIZE];

    logic             accept_s;
    logic             busy_s;
    logic             io_drive_s;
    logic [7:0]       io_value_s;

    // Write acceptance, busy flag and bus drive decode.
    always_comb begin
        accept_s   = rst_n & en_q & ~i_en & ~rw_q_r & ~abort_r;
        busy_s     = (busy_cnt_r != 8'd0);
        io_drive_s = rst_n & i_en & i_rw;
        io_value_s = i_wdata_sel ? i_wdata : {busy_s, ac_r};
    end

    assign io_data = io_drive_s ? io_value_s : 8'hzz;

    // Strobe capture, write acceptance and LCD state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            abort_r     <= 1'b1;
            data_q_r    <= 8'h00;
            rs_q_r      <= 1'b0;
            rw_q_r      <= 1'b0;
            busy_cnt_r  <= 8'd0;
            ac_r        <= 7'd0;
            wr_ptr_r    <= '0;
            entry_cnt_r <= '0;
            o_rdata     <= 8'h00;
            o_rdata_val <= 1'b0;
        end else begin
            en_q <= i_en;
            if (!i_en) begin
                abort_r <= 1'b0;
            end
            // rw is tracked on every enabled cycle so a read strobe can never
            // be mistaken for a write on its falling edge.
            if (i_en) begin
                rw_q_r <= i_rw;
                if (!i_rw) begin
                    data_q_r <= io_data;
                    rs_q_r   <= i_rs;
                end
            end
            o_rdata_val <= accept_s;
            if (accept_s) begin
                o_rdata    <= data_q_r;
                busy_cnt_r <= i_busy_flag_duration;
                ac_r       <= ac_next(ac_r, rs_q_r, data_q_r);
                wr_ptr_r   <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + PTR_ONE;
                if (entry_cnt_r != CNT_MAX) begin
                    entry_cnt_r <= entry_cnt_r + CNT_ONE;
                end
            end else if (busy_cnt_r != 8'd0) begin
                busy_cnt_r <= busy_cnt_r - 8'd1;
            end
        end
    end

    // Command log storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            cmd_buffer[wr_ptr_r] <= {rs_q_r, data_q_r};
        end
    end

endmodule

// File: tb/tb_lcd_cfah_emul.sv
// -----------------------------------------------------------------------------
// tb_lcd_cfah_emul
// Directed self-checking bench for lcd_cfah_emul. The bus carries pull-ups, so
// an undriven (high-impedance) io_data reads back as 8'hFF.
// -----------------------------------------------------------------------------
module tb_lcd_cfah_emul;

    logic       clk;
    logic       rst_n;
    logic       i_rs;
    logic       i_rw;
    logic       i_en;
    wire  [7:0] io_data;
    logic [7:0] i_busy_flag_duration;
    logic [7:0] i_wdata;
    logic       i_wdata_sel;
    logic [7:0] o_rdata;
    logic       o_rdata_val;

    logic       drv_en;
    logic [7:0] drv_val;

    int checks = 0;
    int errors = 0;

    assign io_data = drv_en ? drv_val : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (io_data[g]);
    end

    lcd_cfah_emul #(.G_RECEIVED_CMD_BUFFER_SIZE(256)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_rs                 (i_rs),
        .i_rw                 (i_rw),
        .i_en                 (i_en),
        .io_data              (io_data),
        .i_busy_flag_duration (i_busy_flag_duration),
        .i_wdata              (i_wdata),
        .i_wdata_sel          (i_wdata_sel),
        .o_rdata              (o_rdata),
        .o_rdata_val          (o_rdata_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Host write: enable high for ncyc cycles, then low; returns 1 ns after
    // the edge on which the write is accepted.
    task automatic write_byte(input logic rs, input logic [7:0] b, input int ncyc);
        i_rs    = rs;
        i_rw    = 1'b0;
        drv_val = b;
        drv_en  = 1'b1;
        i_en    = 1'b1;
        repeat (ncyc) tick();
        chk("val_during_strobe", {15'd0, o_rdata_val}, 16'h0000);
        i_en = 1'b0;
        tick();
        drv_en = 1'b0;
    endtask

    task automatic begin_read(input logic sel);
        i_wdata_sel = sel;
        i_rw        = 1'b1;
        i_en        = 1'b1;
        #1;
    endtask

    task automatic end_read();
        i_en = 1'b0;
        tick();
        i_rw = 1'b0;
        chk("read_no_val", {15'd0, o_rdata_val}, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; i_rs = 1'b0; i_rw = 1'b0; i_en = 1'b0;
        i_busy_flag_duration = 8'd0; i_wdata = 8'h00; i_wdata_sel = 1'b0;
        drv_en = 1'b0; drv_val = 8'h00;

        // Reset: bus stays released even with a read strobe present.
        repeat (2) tick();
        i_en = 1'b1; i_rw = 1'b1; i_wdata_sel = 1'b1; i_wdata = 8'h5A;
        repeat (2) tick();
        chk("rst_bus_hiz", {8'd0, io_data}, 16'h00FF);
        i_en = 1'b0; i_rw = 1'b0; i_wdata_sel = 1'b0;
        tick();
        chk("rst_rdata", {8'd0, o_rdata}, 16'h0000);
        chk("rst_val", {15'd0, o_rdata_val}, 16'h0000);
        chk("rst_io_hiz", {8'd0, io_data}, 16'h00FF);
        rst_n = 1'b1;
        tick();

        // Function set 0x38 with a 10-cycle strobe.
        write_byte(1'b0, 8'h38, 10);
        chk("w38_rdata", {8'd0, o_rdata}, 16'h0038);
        chk("w38_val_hi", {15'd0, o_rdata_val}, 16'h0001);
        tick();
        chk("w38_val_lo", {15'd0, o_rdata_val}, 16'h0000);
        chk("w38_hold", {8'd0, o_rdata}, 16'h0038);
        chk("w38_buf0", {7'd0, dut.cmd_buffer[0]}, 16'h0038);
        chk("w38_entries", 16'(dut.entry_cnt_r), 16'd1);

        // Two data writes advance AC to 2.
        write_byte(1'b1, 8'h41, 1);
        write_byte(1'b1, 8'h42, 1);
        chk("data_buf2", {7'd0, dut.cmd_buffer[2]}, 16'h0142);
        begin_read(1'b0);
        chk("status_ac2", {8'd0, io_data}, 16'h0002);
        end_read();
        chk("rdata_hold_after_read", {8'd0, o_rdata}, 16'h0042);

        // Set DDRAM address 0x45.
        write_byte(1'b0, 8'hC5, 1);
        chk("ddram_rdata", {8'd0, o_rdata}, 16'h00C5);
        begin_read(1'b0);
        chk("status_ac45", {8'd0, io_data}, 16'h0045);
        end_read();

        // Clear display with 10-cycle busy time.
        i_busy_flag_duration = 8'd10;
        write_byte(1'b0, 8'h01, 1);
        begin_read(1'b0);
        chk("busy_start", {8'd0, io_data}, 16'h0080);
        repeat (9) tick();
        chk("busy_last", {8'd0, io_data}, 16'h0080);
        tick();
        chk("busy_done", {8'd0, io_data}, 16'h0000);
        end_read();

        // Read back i_wdata.
        i_wdata = 8'hA5;
        begin_read(1'b1);
        chk("wdata_read", {8'd0, io_data}, 16'h00A5);
        end_read();
        chk("wdata_hiz_after", {8'd0, io_data}, 16'h00FF);

        // Write while busy reloads the countdown.
        i_busy_flag_duration = 8'd5;
        write_byte(1'b1, 8'h41, 1);
        write_byte(1'b1, 8'h42, 1);
        begin_read(1'b0);
        chk("reload_start", {8'd0, io_data}, 16'h0082);
        repeat (4) tick();
        chk("reload_last", {8'd0, io_data}, 16'h0082);
        tick();
        chk("reload_done", {8'd0, io_data}, 16'h0002);
        end_read();

        // Reset during a long busy period.
        i_busy_flag_duration = 8'd200;
        write_byte(1'b1, 8'h30, 1);
        repeat (20) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        begin_read(1'b0);
        chk("rst_busy_status", {8'd0, io_data}, 16'h0000);
        end_read();
        chk("rst_ac", {9'd0, dut.ac_r}, 16'h0000);
        chk("rst_entries", 16'(dut.entry_cnt_r), 16'd0);
        chk("rst_rdata2", {8'd0, o_rdata}, 16'h0000);

        // Reset mid-strobe: the aborted write must not be accepted.
        i_busy_flag_duration = 8'd0;
        i_rs = 1'b1; i_rw = 1'b0; drv_val = 8'h77; drv_en = 1'b1; i_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        i_en = 1'b0;
        tick();
        drv_en = 1'b0;
        chk("abort_val", {15'd0, o_rdata_val}, 16'h0000);
        chk("abort_rdata", {8'd0, o_rdata}, 16'h0000);
        chk("abort_entries", 16'(dut.entry_cnt_r), 16'd0);

        // 257 writes: wrap-around overwrites entry 0, counter saturates.
        for (int i = 0; i < 256; i++) begin
            write_byte(1'b0, 8'(i), 1);
        end
        chk("full_entries", 16'(dut.entry_cnt_r), 16'd256);
        write_byte(1'b1, 8'hEE, 1);
        chk("wrap_buf0", {7'd0, dut.cmd_buffer[0]}, 16'h01EE);
        chk("wrap_buf1", {7'd0, dut.cmd_buffer[1]}, 16'h0001);
        chk("wrap_entries", 16'(dut.entry_cnt_r), 16'd256);
        chk("wrap_ptr", 16'(dut.wr_ptr_r), 16'd1);
        chk("wrap_rdata", {8'd0, o_rdata}, 16'h00EE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
